prog_load_ctrl: RTL
===================

Name: prog_load_ctrl

Overview:
- Parametrised program-load and run controller sitting between the UART byte receiver, the mode push-buttons and the CPU instruction memory write port.
- Assembles INSTR_W-bit instructions from consecutive UART bytes, MSB first, and writes them to sequential addresses.
- Sequences the CPU through four modes: LOAD, RUN, STEP (single-step) and DONE.
- Successor to the fixed 16-bit/8-bit load-and-toggle logic: adds width/depth generalisation, single-step, inter-byte timeout, memory-full detection and a CPU start reset.

Parameters:
- ADDR_W, 8, instruction address width; memory depth is 2^ADDR_W words.
- INSTR_W, 16, instruction width; must be a multiple of 8 and at least 8. NB = INSTR_W/8 bytes per word.
- BYTE_TIMEOUT, 2170, maximum clock cycles allowed between bytes of one word; 0 disables the timeout.

Ports:
- i_clk  in  1  master clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_byte  in  8  received UART byte
- i_rx_dv  in  1  one-cycle strobe; i_rx_byte is valid while high
- i_run_btn  in  1  debounced run button, high while pressed
- i_step_btn  in  1  debounced step button, high while pressed
- i_loopf  in  1  CPU loop/finish flag
- o_mode  out  2  current mode: 0=LOAD, 1=RUN, 2=STEP, 3=DONE
- o_cpu_en  out  1  CPU clock enable
- o_cpu_rst  out  1  one-cycle CPU reset pulse
- o_we  out  1  instruction memory write enable
- o_instr_addr  out  ADDR_W  write address
- o_instr  out  INSTR_W  write data
- o_full  out  1  memory full, sticky until the next LOAD entry
- o_done  out  1  high while in DONE
- o_checksum  out  8  byte checksum (see Optional Feature)

Behaviour:
- Reset (async, i_rst_n=0):
  - mode=LOAD; all outputs 0; byte index, timeout counter and button history registers cleared.
- Button events:
  - An event is a registered falling edge (prev=1, cur=0), i.e. it fires on release.
  - A button held through reset release produces no event until it goes high and then low again.
  - If run and step events occur in the same cycle, run wins.
- Mode transitions:
  - LOAD: run event -> RUN; step event -> STEP. Either transition pulses o_cpu_rst for 1 cycle, coincident with the transition cycle.
  - RUN: o_cpu_en=1 continuously. Run event -> LOAD. Otherwise i_loopf=1 -> DONE. A run event beats i_loopf in the same cycle.
  - STEP: o_cpu_en=0 except for exactly 1 cycle, on the cycle after each step event. Run event -> RUN (no o_cpu_rst). i_loopf=1 -> DONE.
  - DONE: o_cpu_en=0, o_done=1. Run event -> LOAD. Step events are ignored.
- On every entry into LOAD:
  - o_instr_addr=0, byte index=0, o_full=0, checksum=0.
- Word assembly (LOAD only; i_rx_dv is ignored in all other modes):
  - Each byte shifts into the assembly register MSB first; the byte index increments.
  - When byte NB-1 arrives, the assembled word is driven on o_instr and o_we=1 on the next cycle (latency 1). o_instr_addr holds the write address during that cycle and increments on the following cycle.
  - The byte index returns to 0.
- Full:
  - The write to address 2^ADDR_W-1 sets o_full=1 on the o_we cycle. o_instr_addr stays at 2^ADDR_W-1 and does not wrap.
  - While o_full=1, completed words are discarded: no o_we. Bytes are still counted into the checksum.
- Timeout:
  - The counter clears on every accepted byte and counts while byte index is not 0.
  - When it reaches BYTE_TIMEOUT, the byte index clears and the partial word is discarded. The address is unchanged.
  - The timeout is inactive when the byte index is 0 or BYTE_TIMEOUT=0.
- Leaving LOAD mid-word: the partial word is discarded; the byte index clears.
- NB=1: every byte is a complete word.

Optional Feature:
- Macro PROG_CHECKSUM_EN.
- Defined:
  - o_checksum = sum mod 256 of all bytes accepted in LOAD since the last LOAD entry, including bytes of partial or discarded words.
  - Updated the cycle after each i_rx_dv.
- Undefined: o_checksum is tied to 0, and no adder or register is synthesised. The port list is unchanged in both cases.

Test Plan:
- Reset, then bytes 0x12, 0x34, 0x56, 0x78 in LOAD (INSTR_W=16) -> o_we pulses with (addr 0, 0x1234) then (addr 1, 0x5678); o_instr_addr ends at 2; o_checksum=0x14 with the macro, 0 without.
- ADDR_W=2: send 5 words -> writes to addrs 0..3 only; o_full=1 from the 4th write; the 5th word produces no o_we; addr stays 3.
- BYTE_TIMEOUT=10: byte 0xAA, wait 12 cycles, then 0xBB, 0xCC -> single write (addr 0, 0xBBCC).
- LOAD, press/release run -> o_cpu_rst 1-cycle pulse, mode=1, o_cpu_en=1; assert i_loopf -> mode=3, o_done=1, o_cpu_en=0; run event -> mode=0, addr=0.
- LOAD, step event -> mode=2 with o_cpu_rst pulse; 3 further step events -> exactly 3 single-cycle o_cpu_en pulses; run and step released in the same cycle -> mode=1.
- Drop i_rst_n mid-word while in RUN -> immediately mode=0, all outputs 0; the next 2 bytes form a complete word written at addr 0.

Source files
------------

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: UART program loader and LOAD/RUN/STEP/DONE run controller for the CPU.
// Define PROG_CHECKSUM_EN to enable the byte checksum on o_checksum (otherwise it is tied to 0).
module prog_load_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int INSTR_W      = 16,
    parameter int BYTE_TIMEOUT = 2170
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [7:0]         i_rx_byte,
    input  logic               i_rx_dv,
    input  logic               i_run_btn,
    input  logic               i_step_btn,
    input  logic               i_loopf,
    output logic [1:0]         o_mode,
    output logic               o_cpu_en,
    output logic               o_cpu_rst,
    output logic               o_we,
    output logic [ADDR_W-1:0]  o_instr_addr,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_full,
    output logic               o_done,
    output logic [7:0]         o_checksum
);
    localparam int NB = INSTR_W / 8;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    localparam int CW = BYTE_TIMEOUT > 1 ? $clog2(BYTE_TIMEOUT + 1) : 1;
    localparam logic [1:0] LOAD = 2'd0, RUN = 2'd1, STEP = 2'd2, DONE = 2'd3;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [1:0]         mode, mode_nxt;
    logic               run_prev, step_prev, step_pulse;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      cnt;
    logic [INSTR_W-1:0] asm_q, asm_nxt;
    logic [ADDR_W-1:0]  wa;
    logic               run_ev, step_ev, enter_load, stay_load, byte_ok, word_end, timed_out;

    assign run_ev     = run_prev & ~i_run_btn;
    assign step_ev    = step_prev & ~i_step_btn;
    // run events take priority over step events and over i_loopf
    assign mode_nxt   = (mode == LOAD) ? (run_ev ? RUN : step_ev ? STEP : LOAD)
                      : (mode == DONE) ? (run_ev ? LOAD : DONE)
                      : run_ev ? ((mode == RUN) ? LOAD : RUN)
                      : i_loopf ? DONE : mode;
    assign enter_load = (mode != LOAD) && (mode_nxt == LOAD);
    assign stay_load  = (mode == LOAD) && (mode_nxt == LOAD);
    assign byte_ok    = stay_load && i_rx_dv;
    assign asm_nxt    = INSTR_W'({asm_q, i_rx_byte});
    assign word_end   = byte_ok && (idx == IW'(NB - 1));
    assign timed_out  = (BYTE_TIMEOUT != 0) && (idx != '0) && !i_rx_dv && (cnt == CW'(BYTE_TIMEOUT));
    // address the next completed word will use: bumped once the previous write cycle is over
    assign wa         = (o_we && o_instr_addr != ADDR_MAX) ? o_instr_addr + 1'b1 : o_instr_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode         <= LOAD;
            run_prev     <= 1'b0;
            step_prev    <= 1'b0;
            step_pulse   <= 1'b0;
            idx          <= '0;
            cnt          <= '0;
            asm_q        <= '0;
            o_cpu_rst    <= 1'b0;
            o_we         <= 1'b0;
            o_instr_addr <= '0;
            o_instr      <= '0;
            o_full       <= 1'b0;
        end else begin
            mode       <= mode_nxt;
            run_prev   <= i_run_btn;
            step_prev  <= i_step_btn;
            step_pulse <= (mode == STEP) && (mode_nxt == STEP) && step_ev;
            o_cpu_rst  <= (mode == LOAD) && (mode_nxt != LOAD);
            o_we       <= word_end && !o_full;
            cnt        <= (byte_ok || idx == '0) ? '0 : cnt + 1'b1;
            if (byte_ok)
                asm_q <= asm_nxt;
            if (word_end)
                o_instr <= asm_nxt;
            if (enter_load) begin
                o_instr_addr <= '0;
                idx          <= '0;
                o_full       <= 1'b0;
            end else begin
                o_instr_addr <= wa;
                idx          <= (!stay_load || word_end || timed_out) ? '0 : byte_ok ? idx + 1'b1 : idx;
                if (word_end && wa == ADDR_MAX)
                    o_full <= 1'b1;
            end
        end
    end

    assign o_mode   = mode;
    assign o_cpu_en = (mode == RUN) || step_pulse;
    assign o_done   = (mode == DONE);

`ifdef PROG_CHECKSUM_EN
    logic [7:0] sum;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            sum <= '0;
        else if (enter_load)
            sum <= '0;
        else if (byte_ok)
            sum <= sum + i_rx_byte;
    end
    assign o_checksum = sum;
`else
    assign o_checksum = 8'd0;
`endif
endmodule
